// File: rtl/pair_combine_engine.sv
// Pair-combining datapath: reads A[2i], A[2i+1] and writes one combined result to B[i] per pair.
// Runs start on a start pulse, end with a one-cycle done pulse, and report a sticky ovf flag.
module pair_combine_engine #(
    parameter int DATA_W  = 8,
    parameter int A_DEPTH = 8,
    parameter int A_AW    = $clog2(A_DEPTH),
    localparam int B_AW   = (A_AW > 1) ? A_AW - 1 : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              a_we,
    input  logic [A_AW-1:0]   a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [B_AW-1:0]   b_raddr,
    output logic [DATA_W-1:0] b_rdata,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam int B_DEPTH = A_DEPTH / 2;
    localparam logic [B_AW-1:0] LAST_IDX   = B_AW'(B_DEPTH - 1);
    localparam logic [B_AW:0]   B_DEPTH_W  = (B_AW + 1)'(B_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_WR,
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [B_AW-1:0]   idx;
    logic [DATA_W-1:0] op_a, op_b;
    logic              mode_r;
    logic              ovf_r;

    logic [DATA_W-1:0] mem_a [A_DEPTH];
    logic [DATA_W-1:0] mem_b [B_DEPTH];

    logic              host_ok;
    logic              start_ok;
    logic [B_AW:0]     rd_pair;
    logic [DATA_W-1:0] a_rd;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] result;
    logic              carry;

    assign host_ok  = (state == S_IDLE) || (state == S_DONE);
    assign start_ok = (state == S_IDLE) && start;

    // RD0 fetches the even word of the pair, RD1 the odd word
    always_comb begin
        rd_pair = {idx, (state == S_RD1)};
        a_rd    = mem_a[rd_pair[A_AW-1:0]];
    end

    always_comb begin
        sum    = {1'b0, op_a} + {1'b0, op_b};
        result = '0;
        carry  = 1'b0;
        if (op_a >= op_b) begin
            result = op_a - op_b;
        end else if (mode_r) begin
            result = op_b - op_a;
        end else begin
            result = sum[DATA_W-1:0];
            carry  = sum[DATA_W];
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_RD0;
            end
            S_RD0: begin
                busy     = 1'b1;
                state_nx = S_RD1;
            end
            S_RD1: begin
                busy     = 1'b1;
                state_nx = S_WR;
            end
            S_WR: begin
                busy     = 1'b1;
                state_nx = (idx == LAST_IDX) ? S_DONE : S_RD0;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            mode_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                mode_r <= mode;
                ovf_r  <= 1'b0;
                idx    <= '0;
            end
            if (state == S_RD0) op_a <= a_rd;
            if (state == S_RD1) op_b <= a_rd;
            if (state == S_WR) begin
                if (carry) ovf_r <= 1'b1;
                if (idx != LAST_IDX) idx <= idx + 1'b1;
            end
        end
    end

    // Host writes are locked out for the whole run so the operands stay stable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned j = 0; j < A_DEPTH; j++) mem_a[j] <= '0;
            for (int unsigned j = 0; j < B_DEPTH; j++) mem_b[j] <= '0;
        end else begin
            if (a_we && host_ok) mem_a[a_addr] <= a_wdata;
            if (state == S_WR)   mem_b[idx]    <= result;
        end
    end

    assign b_rdata = ({1'b0, b_raddr} < B_DEPTH_W) ? mem_b[b_raddr] : '0;
    assign ovf     = ovf_r;

endmodule

// File: doc/pair_combine_engine.md
Name: pair_combine_engine

Overview:
- Parametrised successor to the two-memory, compare/add/sub/mux datapath.
- Combines consecutive pairs of source memory A (A[2i], A[2i+1]) into result memory B[i] under an internal FSM, driven by a start/done handshake.
- Adds configurable width and depth, a runtime arithmetic mode, a sticky overflow flag and host access ports for loading A and reading back B.
- Sits between the host/testbench loader and downstream consumers of B.

Parameters:
- DATA_W, 8, operand/result width in bits.
- A_DEPTH, 8, number of A words; power of two, >= 2; B depth = A_DEPTH/2.
- A_AW, log2(A_DEPTH), A address width; B address width = A_AW-1 (minimum 1).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- mode  in  1  0 = compare-select (a>=b ? a-b : a+b); 1 = absolute difference |a-b|; captured at start.
- a_we  in  1  host write enable for A.
- a_addr  in  A_AW  host write address for A.
- a_wdata  in  DATA_W  host write data for A.
- b_raddr  in  A_AW-1  host read address for B.
- b_rdata  out  DATA_W  combinational read of B[b_raddr].
- busy  out  1  high from the cycle after start is accepted through the last write cycle.
- done  out  1  one-cycle pulse after the final B write.
- ovf  out  1  sticky flag: any mode-0 addition carried out of DATA_W during the current or last run.

Behaviour:
- Reset (async, reset=1): FSM to IDLE, pair index 0, operand registers 0, busy=0, done=0, ovf=0, mode register 0, all A and B words 0 (so b_rdata=0).
- States: IDLE, RD0, RD1, WR, DONE.
- IDLE, start=1 at edge k: capture mode, clear ovf, pair index i=0, go to RD0. busy=1 from this edge.
- RD0: opA <= A[2i]; go to RD1.
- RD1: opB <= A[2i+1]; go to WR.
- WR: B[i] <= result. If i == A_DEPTH/2-1, go to DONE; otherwise increment i and go to RD0.
- DONE: done=1, busy=0 for exactly one cycle; then go to IDLE.
- Timing: 3 cycles per pair. The last B write occurs at edge k+3·(A_DEPTH/2); done is high in the following cycle.
- A reads are combinational from the register array. B writes are synchronous.
- Arithmetic, mode 0:
  - opA >= opB (unsigned): result = opA - opB.
  - Otherwise: result = (opA + opB) mod 2^DATA_W, and ovf <= 1 if the (DATA_W+1)-bit sum has its MSB set.
- Arithmetic, mode 1: result = (opA >= opB) ? opA - opB : opB - opA. ovf is never set.
- Equality (opA == opB): the subtract path applies, giving result 0 in both modes.
- ovf holds its value through DONE and IDLE; it is cleared only by reset or the next accepted start.
- Host writes to A:
  - Accepted only in IDLE or DONE.
  - Ignored while busy=1, so the operands of a run are stable.
  - A write and a start in the same IDLE cycle: the write lands at that edge; RD0 reads the new value.
- start while busy or in DONE is ignored; there is no queuing.
- The mode input is ignored after capture; changing it mid-run has no effect.
- b_rdata may be read at any time. During a run it reflects B as written so far, plus prior-run contents for pairs not yet rewritten.
- Reset mid-run: immediate abort to IDLE, with all state and memories cleared as above; done is not pulsed.
- Pair index wraps only through the WR→DONE exit; B is never addressed out of range.

Test Plan:
1. Defaults, mode 0. Load A = {20,5, 3,9, 200,100, 7,7}; pulse start.
   -> B = {15, 12, 100, 0}; done pulse 13 cycles after start edge; busy high for 12 cycles; ovf=0.
2. Overflow. Mode 0, load A = {100,200, ...}.
   -> B[0] = 44 (300 mod 256), ovf=1.
   Then rerun with mode 1 -> B[0] = 100, ovf cleared at start and remains 0.
3. Absolute difference. Mode 1, A = {5,20, 9,3, 0,255, 128,128}.
   -> B = {15, 6, 255, 0}.
4. Protection. During a run, assert a_we to A[0] and re-pulse start.
   -> A[0] unchanged; B matches the original data; exactly one done pulse.
5. Reset mid-run. Assert reset during the second RD1.
   -> busy=0, done=0, ovf=0, b_rdata=0 for all addresses. A fresh run after release completes correctly.
6. Parametrised instance. DATA_W=4, A_DEPTH=2, A = {3,12}, mode 0.
   -> B[0] = 15, ovf=0, done 4 cycles after start edge.
